// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle processor control FSM (FETCH/DECODE/EXEC/MEM/WB)
// Optional build macro: MC_CONTROL_MEMWAIT_EN (MEM holds until mem_ready is sampled high)
module mc_control #(
  parameter int OPW        = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] inst,
  input  logic           inst_valid,
  input  logic           mem_ready,
  output logic           irwrite,
  output logic           pcwrite,
  output logic           wen,
  output logic           alusrc,
  output logic           regdst,
  output logic           memwrite,
  output logic           memread,
  output logic           memtoreg,
  output logic           branch,
  output logic [2:0]     aluop,
  output logic           busy,
  output logic           illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [OPW-1:0] OP_SLL = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL = OPW'(6);
  localparam logic [OPW-1:0] OP_MUL = OPW'(7);
  localparam logic [OPW-1:0] OP_LW  = OPW'(8);
  localparam logic [OPW-1:0] OP_SW  = OPW'(9);
  localparam logic [OPW-1:0] OP_BEQ = OPW'(10);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t         state, state_nx;
  logic [OPW-1:0] ir;
  logic [3:0]     cnt, cnt_nx;
  logic           ir_load;
  logic           mem_done;

  // Opcode classes decoded from the latched IR; upper opcode bits take part in
  // the legality compare so any nonzero high bit makes the opcode undefined.
  logic is_mul, is_lw, is_sw, is_beq, is_shift, legal;
  assign is_mul   = (ir == OP_MUL);
  assign is_lw    = (ir == OP_LW);
  assign is_sw    = (ir == OP_SW);
  assign is_beq   = (ir == OP_BEQ);
  assign is_shift = (ir == OP_SLL) || (ir == OP_SRL);
  assign legal    = (ir <= OP_BEQ);

`ifdef MC_CONTROL_MEMWAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  // State, instruction register and MUL down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      ir    <= '0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ir_load) begin
        ir <= inst;
      end
    end
  end

  // Next-state logic and Moore-style control decode from state and IR
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ir_load  = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    wen      = 1'b0;
    alusrc   = 1'b0;
    regdst   = 1'b0;
    memwrite = 1'b0;
    memread  = 1'b0;
    memtoreg = 1'b0;
    branch   = 1'b0;
    aluop    = 3'b000;
    busy     = (state != FETCH);
    illegal  = 1'b0;

    case (state)
      FETCH: begin
        // rst_n gating keeps the accept pulses low while reset is held
        if (inst_valid && rst_n) begin
          irwrite  = 1'b1;
          pcwrite  = 1'b1;
          ir_load  = 1'b1;
          state_nx = DECODE;
        end
      end
      DECODE: begin
        if (!legal) begin
          illegal  = 1'b1;
          state_nx = FETCH;
        end else begin
          state_nx = EXEC;
          cnt_nx   = is_mul ? MUL_LOAD : 4'd0;
        end
      end
      EXEC: begin
        aluop  = (is_lw || is_sw) ? 3'b000 : ir[2:0];
        alusrc = is_shift || is_lw || is_sw;
        if (is_beq) begin
          branch   = 1'b1;
          regdst   = 1'b1;
          state_nx = FETCH;
        end else if (is_lw || is_sw) begin
          state_nx = MEM;
        end else if (is_mul && (cnt != 4'd0)) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          state_nx = WB;
        end
      end
      MEM: begin
        memread  = is_lw;
        memwrite = is_sw;
        regdst   = is_sw;
        if (mem_done) begin
          state_nx = is_lw ? WB : FETCH;
        end
      end
      WB: begin
        wen      = 1'b1;
        memtoreg = is_lw;
        state_nx = FETCH;
      end
      default: begin
        state_nx = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed self-checking bench for mc_control
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] inst;
  logic       inst_valid;
  logic       mem_ready;
  logic       irwrite, pcwrite, wen, alusrc, regdst, memwrite, memread;
  logic       memtoreg, branch, busy, illegal;
  logic [2:0] aluop;

  int n_cmp = 0;
  int n_err = 0;

  // Bit positions of the packed control vector compared each step
  localparam logic [13:0] IRW  = 14'h2000;
  localparam logic [13:0] PCW  = 14'h1000;
  localparam logic [13:0] WEN  = 14'h0800;
  localparam logic [13:0] ASRC = 14'h0400;
  localparam logic [13:0] RDST = 14'h0200;
  localparam logic [13:0] MWR  = 14'h0100;
  localparam logic [13:0] MRD  = 14'h0080;
  localparam logic [13:0] MTR  = 14'h0040;
  localparam logic [13:0] BR   = 14'h0020;
  localparam logic [13:0] BUSY = 14'h0002;
  localparam logic [13:0] ILL  = 14'h0001;
  localparam logic [13:0] ACC  = IRW | PCW;

  mc_control #(.OPW(4), .MUL_CYCLES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .inst_valid (inst_valid),
    .mem_ready  (mem_ready),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .wen        (wen),
    .alusrc     (alusrc),
    .regdst     (regdst),
    .memwrite   (memwrite),
    .memread    (memread),
    .memtoreg   (memtoreg),
    .branch     (branch),
    .aluop      (aluop),
    .busy       (busy),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] al(input logic [2:0] v);
    return {9'd0, v, 2'b00};
  endfunction

  // Inputs are set at a falling edge; outputs are sampled 2 time units later
  task automatic step(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    #2;
    obs = {irwrite, pcwrite, wen, alusrc, regdst, memwrite, memread,
           memtoreg, branch, aluop, busy, illegal};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    inst       = 4'd0;
    inst_valid = 1'b1;
    mem_ready  = 1'b0;
    step("reset_outputs", 14'h0);

    // ADD accepted on the first edge after reset release
    rst_n = 1'b1;
    step("add_c0", ACC);
    inst_valid = 1'b0;
    inst       = 4'hF;
    step("add_c1", BUSY);
    step("add_c2", BUSY | al(3'b000));
    step("add_c3", BUSY | WEN);
    step("add_c4", 14'h0);

    // MUL with inst_valid left high while busy: must not re-accept
    inst = 4'd7; inst_valid = 1'b1;
    step("mul_c0", ACC);
    inst = 4'd0;
    step("mul_c1", BUSY);
    step("mul_c2", BUSY | al(3'b111));
    step("mul_c3", BUSY | al(3'b111));
    step("mul_c4", BUSY | al(3'b111));
    inst_valid = 1'b0;
    step("mul_c5", BUSY | WEN);
    step("mul_c6", 14'h0);

    // SLL uses the immediate operand
    inst = 4'd5; inst_valid = 1'b1;
    step("sll_c0", ACC);
    inst_valid = 1'b0;
    step("sll_c1", BUSY);
    step("sll_c2", BUSY | ASRC | al(3'b101));
    step("sll_c3", BUSY | WEN);
    step("sll_c4", 14'h0);

    // BEQ
    inst = 4'd10; inst_valid = 1'b1;
    step("beq_c0", ACC);
    inst_valid = 1'b0;
    step("beq_c1", BUSY);
    step("beq_c2", BUSY | BR | RDST | al(3'b010));
    step("beq_c3", 14'h0);

    // Undefined opcode
    inst = 4'hF; inst_valid = 1'b1;
    step("ill_c0", ACC);
    inst_valid = 1'b0;
    step("ill_c1", BUSY | ILL);
    step("ill_c2", 14'h0);

    // Smallest undefined opcode
    inst = 4'd11; inst_valid = 1'b1;
    step("ill11_c0", ACC);
    inst_valid = 1'b0;
    step("ill11_c1", BUSY | ILL);
    step("ill11_c2", 14'h0);

    // SW
    inst = 4'd9; inst_valid = 1'b1;
    step("sw_c0", ACC);
    inst_valid = 1'b0;
    step("sw_c1", BUSY);
`ifdef MC_CONTROL_MEMWAIT_EN
    mem_ready = 1'b1;
`endif
    step("sw_c2", BUSY | ASRC | al(3'b000));
    step("sw_c3", BUSY | MWR | RDST);
    mem_ready = 1'b0;
    step("sw_c4", 14'h0);

    // LW
    inst = 4'd8; inst_valid = 1'b1;
    step("lw_c0", ACC);
    inst_valid = 1'b0;
    step("lw_c1", BUSY);
    step("lw_c2", BUSY | ASRC | al(3'b000));
    step("lw_c3", BUSY | MRD);
`ifdef MC_CONTROL_MEMWAIT_EN
    step("lw_c4", BUSY | MRD);
    step("lw_c5", BUSY | MRD);
    mem_ready = 1'b1;
    step("lw_c6", BUSY | MRD);
    mem_ready = 1'b0;
    step("lw_c7", BUSY | WEN | MTR);
    step("lw_c8", 14'h0);
`else
    step("lw_c4", BUSY | WEN | MTR);
    step("lw_c5", 14'h0);
`endif

    // Reset asserted during the second MUL EXEC cycle aborts the instruction
    inst = 4'd7; inst_valid = 1'b1;
    step("mrst_c0", ACC);
    inst_valid = 1'b0;
    step("mrst_c1", BUSY);
    step("mrst_c2", BUSY | al(3'b111));
    rst_n = 1'b0;
    step("mrst_async", 14'h0);
    rst_n = 1'b1;
    step("mrst_post0", 14'h0);
    step("mrst_post1", 14'h0);
    step("mrst_post2", 14'h0);

    // ADD after the aborted MUL completes normally
    inst = 4'd0; inst_valid = 1'b1;
    step("add2_c0", ACC);
    inst_valid = 1'b0;
    step("add2_c1", BUSY);
    step("add2_c2", BUSY | al(3'b000));
    step("add2_c3", BUSY | WEN);
    step("add2_c4", 14'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter OPW, default 4, opcode width (>=4; upper bits beyond [3:0] SHALL be zero for legal opcodes).
REQ-002 Parameter MUL_CYCLES, default 3, execute-stage occupancy of MUL (1..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 inst  input  OPW  opcode of next instruction, sampled when accepted.
REQ-006 inst_valid  input  1  inst holds a valid opcode.
REQ-007 mem_ready  input  1  data memory completes the current access.
REQ-008 irwrite, pcwrite  output  1 each  latch opcode / advance PC (one-cycle pulses).
REQ-009 wen, alusrc, regdst, memwrite, memread, memtoreg, branch  output  1 each  datapath controls.
REQ-010 aluop  output  3  ALU operation.
REQ-011 busy  output  1  high in every state except FETCH.
REQ-012 illegal  output  1  one-cycle pulse on undefined opcode.

Function
REQ-013 Opcodes SHALL be ADD=0, SUB=1, AND=2, XOR=3, COM=4, SLL=5, SRL=6, MUL=7, LW=8, SW=9, BEQ=10; all others undefined.
REQ-014 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB.
REQ-015 FETCH: if inst_valid, pulse irwrite and pcwrite, capture inst into internal IR, go DECODE; else stay.
REQ-016 DECODE: one cycle; undefined opcode -> pulse illegal, go FETCH, no write/branch asserted; otherwise go EXEC.
REQ-017 EXEC: aluop = IR[2:0] for opcodes 0-7 and BEQ (IR[2:0]=010), 000 for LW/SW; alusrc=1 for SLL, SRL, LW, SW, else 0; held for whole state.
REQ-018 EXEC for opcodes 0-6 SHALL last 1 cycle then WB; MUL SHALL last exactly MUL_CYCLES cycles (down-counter) then WB.
REQ-019 EXEC for BEQ: assert branch and regdst=1 for 1 cycle, go FETCH.
REQ-020 EXEC for LW/SW: 1 cycle, go MEM.
REQ-021 MEM: LW asserts memread, SW asserts memwrite and regdst=1; SW completion -> FETCH, LW completion -> WB.
REQ-022 WB: wen=1 for exactly 1 cycle, memtoreg=1 only for LW, regdst=0, then FETCH.
REQ-023 Outputs SHALL be Moore-decoded from state and IR; every control not named for a state SHALL be 0 in that state.
REQ-024 Latency inst accept to next FETCH: ALU ops 4 cycles, MUL 3+MUL_CYCLES, BEQ 3, SW 4, LW 5 (no memory wait).
REQ-025 inst and inst_valid SHALL be ignored while busy; inst changes outside FETCH SHALL not affect IR.

Reset
REQ-026 rst_n low SHALL immediately force state FETCH, IR=0, MUL counter=0, all outputs 0.
REQ-027 Reset mid-instruction SHALL abort it; no wen, memwrite or branch pulse after rst_n deasserts until a new instruction is accepted.
REQ-028 First acceptance SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-029 Macro MC_CONTROL_MEMWAIT_EN defined: MEM SHALL hold, keeping memread/memwrite asserted, until mem_ready=1 is sampled; completion on that edge.
REQ-030 Macro undefined: MEM SHALL last exactly 1 cycle; mem_ready SHALL be ignored.

Verification
REQ-031 Reset then inst=ADD(0) with inst_valid -> irwrite/pcwrite cycle 0, aluop=000 alusrc=0 cycle 2, wen=1 only cycle 3, busy low cycle 4.
REQ-032 inst=MUL(7), MUL_CYCLES=3 -> aluop=111 for cycles 2-4, wen=1 cycle 5, no other wen.
REQ-033 inst=LW(8), MEMWAIT_EN defined, mem_ready low 3 cycles then high -> memread cycles 3-6, wen=1 and memtoreg=1 cycle 7.
REQ-034 inst=BEQ(10) -> branch=1, regdst=1, aluop=010 cycle 2 only; wen and memwrite never asserted; FETCH cycle 3.
REQ-035 inst=4'hF -> illegal pulse cycle 1, no control asserted, FETCH cycle 2; then inst=SW(9) -> memwrite=1 single cycle (macro undefined).
REQ-036 rst_n low during MUL EXEC cycle 3 -> all outputs 0 asynchronously, no wen after release, next ADD completes normally.
